// File: rtl/seq_alu.sv
// seq_alu: WIDTH-bit ALU with registered outputs and valid/ready handshakes on
// both sides. Logic/arith/shift ops finish in one cycle. MULLO/MULHI/DIVU/REMU
// run on a radix-2 iterative engine that takes exactly WIDTH steps, whatever the data.
//
// Handshake: an input transfer happens on a rising edge where in_valid & in_ready.
// in_ready depends only on the FSM state. An output transfer happens where
// out_valid & out_ready. out_valid and result/zero/ovf stay stable until that
// transfer.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [1:0]       op_q, op_d;       // 00 MULLO, 01 MULHI, 10 DIVU, 11 REMU
  logic [WIDTH-1:0] a_q, a_d;         // multiplicand
  logic [WIDTH-1:0] b_q, b_d;         // divisor
  logic [WIDTH-1:0] hi_q, hi_d;       // mul: product high half / div: partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // mul: multiplier -> product low half / div: dividend -> quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] add_res, sub_res, sc_res;
  logic             sc_ovf, is_iter;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo, step_res;
  logic             div_ge;

  assign add_res = a + b;
  assign sub_res = a - b;
  assign is_iter = (alu_op[3:2] == 2'b10);

  // Single-cycle datapath: evaluated on the live operands at the transfer edge
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_op)
      4'b0000: sc_res = a & b;
      4'b0001: sc_res = a | b;
      4'b0010: begin
        sc_res = add_res;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        sc_res = sub_res;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: sc_res = WIDTH'($signed(a) < $signed(b));
      4'b0011: sc_res = a ^ b;
      4'b0100: sc_res = a << b[SHW-1:0];
      4'b0101: sc_res = a >> b[SHW-1:0];
      4'b1100: sc_res = ~(a | b);
      default: sc_res = '0;
    endcase
  end

  // One radix-2 step of the iterative engine: shift-add multiply or restoring divide.
  // A zero divisor always compares as "fits", so the quotient fills with ones and the
  // remainder ends up equal to the dividend. No special case is needed for it.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (!op_q[1]) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
    step_res = op_q[0] ? step_hi : step_lo;
  end

  // FSM next-state and register updates
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_iter) begin
            state_d = S_BUSY;
            count_d = '0;
            op_d    = alu_op[1:0];
            a_d     = a;
            b_d     = b;
            hi_d    = '0;
            lo_d    = alu_op[1] ? a : b;
          end else begin
            state_d     = S_DONE;
            result_d    = sc_res;
            zero_d      = (sc_res == '0);
            ovf_d       = sc_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + SHW'(1);
        if (count_q == LAST_STEP) begin
          state_d     = S_DONE;
          result_d    = step_res;
          zero_d      = (step_res == '0);
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu. It runs directed corner cases, a mid-operation reset and
// randomized operations, and compares every result against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W-1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         in_ready, out_valid, zero, ovf;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  // Scoreboard entries: {ovf, zero, result}
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf),
    .dbg_state_o(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint          sx, sy, s;
    longint unsigned p;
    logic [W-1:0]    r;
    logic [4:0]      sh;
    logic            v;
    sx = $signed(x);
    sy = $signed(y);
    p  = {32'd0, x} * {32'd0, y};
    sh = y[4:0];
    r  = '0;
    v  = 1'b0;
    s  = 0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin s = sx + sy; r = x + y; v = (s > SMAX) || (s < SMIN); end
      4'b0110: begin s = sx - sy; r = x - y; v = (s > SMAX) || (s < SMIN); end
      4'b0111: r = W'(sx < sy);
      4'b0011: r = x ^ y;
      4'b0100: r = x << sh;
      4'b0101: r = x >> sh;
      4'b1100: r = ~(x | y);
      4'b1000: r = p[31:0];
      4'b1001: r = p[63:32];
      4'b1010: r = (y == 0) ? '1 : x / y;
      4'b1011: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return {v, (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  // Issue one op, measure latency, check the outputs, optionally apply backpressure,
  // then consume the result.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold);
    int           lat, exp_lat;
    bit           ready_leak, hold_bad;
    logic [W+1:0] exp;
    logic [W-1:0] held;
    exp_lat = (op[3:2] == 2'b10) ? W + 1 : 1;
    @(negedge clk);
    a = x; b = y; alu_op = op; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    exp_q.push_back(model(op, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
    lat = 1; ready_leak = 0; hold_bad = 0;
    while (!out_valid && lat < 4 * W) begin
      if (in_ready) ready_leak = 1;
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    exp = exp_q.pop_front();
    check("result", result, exp[W-1:0]);
    check("zero", zero, exp[W]);
    check("ovf", ovf, exp[W+1]);
    if (in_ready) ready_leak = 1;
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; alu_op = 4'($urandom);
      @(posedge clk); #1;
      if (in_ready) ready_leak = 1;
      if (!out_valid || result !== held) hold_bad = 1;
    end
    in_valid = 1'b0;
    check("in_ready_low_busy_done", ready_leak, 0);
    if (hold > 0) check("hold_stable", hold_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]   ops[16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                            4'b0111, 4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101,
                            4'b1110, 4'b1111};
  logic [W-1:0] specials[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return specials[$urandom_range(0, 5)];
      1:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    do_op(4'b0110, 32'd5, 32'd5, 0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(4'b1010, 32'd100, 32'd7, 0);
    do_op(4'b1011, 32'd100, 32'd7, 0);
    do_op(4'b1010, 32'd9, 32'd0, 0);
    do_op(4'b1011, 32'd9, 32'd0, 0);
    do_op(4'b0100, 32'h1, 32'h0000_0105, 10);
    do_op(4'b0110, 32'h8000_0000, 32'h1, 0);

    // reset in the middle of a divide
    do_op(4'b0010, 32'h1234, 32'h1, 0);
    @(negedge clk);
    a = 32'd1000; b = 32'd3; alu_op = 4'b1010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_zero", zero, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b0010, 32'd2, 32'd3, 0);
    do_op(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      do_op(ops[$urandom_range(0, 15)], pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
